// File: rtl/tensor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tensor_pkg
//  Description : Shared geometry, address widths and load-sequencer state
//                encoding for the 8x8x3 activation tensor.
//  Revision    : 1.0 - initial release
// ============================================================================
package tensor_pkg;

    localparam int TENSOR_ROWS  = 8;
    localparam int TENSOR_COLS  = 8;
    localparam int TENSOR_CHANS = 3;
    localparam int TENSOR_ELEMS = TENSOR_ROWS * TENSOR_COLS * TENSOR_CHANS;

    localparam int ROW_W = 3;
    localparam int COL_W = 3;
    localparam int CHA_W = 2;

    // Final index of each dimension; the frame ends at (ROW_LAST, COL_LAST, CHA_LAST)
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(TENSOR_ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(TENSOR_COLS - 1);
    localparam logic [CHA_W-1:0] CHA_LAST = CHA_W'(TENSOR_CHANS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        FULL  = 2'd3
    } tload_state_t;

endpackage
`default_nettype wire

// File: rtl/hwc_addr_counter.sv
`default_nettype none
// ============================================================================
//  Module      : hwc_addr_counter
//  Description : Nested HWC element counter. Channel runs fastest, then
//                column, then row. 'last' flags the final element of a frame.
//                'clr' has priority over 'inc'.
//  Revision    : 1.0 - initial release
// ============================================================================
module hwc_addr_counter
    import tensor_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic [CHA_W-1:0] cha,
    output logic             last
);

    logic row_last;
    logic col_last;
    logic cha_last;

    assign row_last = (row == ROW_LAST);
    assign col_last = (col == COL_LAST);
    assign cha_last = (cha == CHA_LAST);
    assign last     = row_last && col_last && cha_last;

    // Advance channel, carrying into column and row; the row wraps at frame end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row <= '0;
            col <= '0;
            cha <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
            cha <= '0;
        end else if (inc) begin
            if (cha_last) begin
                cha <= '0;
                if (col_last) begin
                    col <= '0;
                    if (row_last) begin
                        row <= '0;
                    end else begin
                        row <= row + 1'b1;
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end else begin
                cha <= cha + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tensor_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tensor_load_ctrl
//  Description : Fills the 8x8x3 activation tensor from a valid/ready pixel
//                stream in HWC order, drives write address/data to
//                tensor_builder, and holds the finished tensor until the
//                consumer acknowledges it.
//                Optional feature macro: TENSOR_LOAD_CTRL_CNT_EN adds the
//                16-bit completed-frame counter output 'frame_cnt'.
//  Revision    : 1.0 - initial release
// ============================================================================
module tensor_load_ctrl
    import tensor_pkg::*;
#(
    parameter int WIDTH = 17
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             cont,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             s_ready,
    output logic [ROW_W-1:0] row_addr,
    output logic [COL_W-1:0] col_addr,
    output logic [CHA_W-1:0] cha_addr,
    output logic [WIDTH-1:0] data_out,
    output logic             tensor_valid,
    input  logic             tensor_ack,
    output logic             busy
`ifdef TENSOR_LOAD_CTRL_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    tload_state_t     state;
    tload_state_t     state_next;

    logic             accept;
    logic             cnt_clr;
    logic             cnt_last;
    logic [ROW_W-1:0] cnt_row;
    logic [COL_W-1:0] cnt_col;
    logic [CHA_W-1:0] cnt_cha;

    // Handshake only while loading; s_ready is a pure state decode
    assign accept  = s_valid && s_ready;
    // Counters restart whenever the sequencer heads back to IDLE (abort or ack)
    assign cnt_clr = (state_next == IDLE);

    hwc_addr_counter u_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (accept),
        .clr  (cnt_clr),
        .row  (cnt_row),
        .col  (cnt_col),
        .cha  (cnt_cha),
        .last (cnt_last)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Moore outputs; abort overrides every other request
    always_comb begin
        state_next   = state;
        s_ready      = 1'b0;
        tensor_valid = 1'b0;
        busy         = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                s_ready = 1'b1;
                if (accept && cnt_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Lets the builder capture the final element before FULL
                state_next = FULL;
            end
            FULL: begin
                tensor_valid = 1'b1;
                if (tensor_ack) begin
                    state_next = cont ? LOAD : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (abort) begin
            state_next = IDLE;
        end
    end

    // Write port to the builder: updated only by an accepted element, held otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_addr <= '0;
            col_addr <= '0;
            cha_addr <= '0;
            data_out <= '0;
        end else if (accept) begin
            row_addr <= cnt_row;
            col_addr <= cnt_col;
            cha_addr <= cnt_cha;
            data_out <= s_data;
        end
    end

`ifdef TENSOR_LOAD_CTRL_CNT_EN
    // Completed-frame counter: counts DRAIN->FULL, survives abort, wraps naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt <= '0;
        end else if ((state == DRAIN) && (state_next == FULL)) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tensor_load_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_tensor_load_ctrl
//  Description : Self-checking bench for tensor_load_ctrl with a behavioural
//                tensor_builder model (writes data_out at the addresses every
//                clock). Honours TENSOR_LOAD_CTRL_CNT_EN for frame_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tensor_load_ctrl;

    localparam int WIDTH = 17;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic             cont;
    logic             s_valid;
    logic [WIDTH-1:0] s_data;
    logic             s_ready;
    logic [2:0]       row_addr;
    logic [2:0]       col_addr;
    logic [1:0]       cha_addr;
    logic [WIDTH-1:0] data_out;
    logic             tensor_valid;
    logic             tensor_ack;
    logic             busy;
`ifdef TENSOR_LOAD_CTRL_CNT_EN
    logic [15:0]      frame_cnt;
`endif

    int total;
    int bad;

    tensor_load_ctrl #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .cont         (cont),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .row_addr     (row_addr),
        .col_addr     (col_addr),
        .cha_addr     (cha_addr),
        .data_out     (data_out),
        .tensor_valid (tensor_valid),
        .tensor_ack   (tensor_ack),
        .busy         (busy)
`ifdef TENSOR_LOAD_CTRL_CNT_EN
        ,
        .frame_cnt    (frame_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Builder model: no write enable, captures the presented element every edge
    logic [WIDTH-1:0] tens [0:191];
    always @(posedge clk) begin
        tens[int'(row_addr) * 24 + int'(col_addr) * 3 + int'(cha_addr)] <= data_out;
    end

    typedef struct packed {
        logic             start;
        logic             abort;
        logic             ack;
        logic             cont;
        logic             vld;
        logic [WIDTH-1:0] din;
        logic             rdy;
        logic             tv;
        logic             bsy;
        logic [2:0]       row;
        logic [2:0]       col;
        logic [1:0]       cha;
        logic [WIDTH-1:0] dout;
    } vec_t;

    vec_t vt [12];

    function automatic vec_t mk(input logic st, input logic ab, input logic ak,
                                input logic vl, input int din,
                                input logic rdy, input logic tv, input logic bsy,
                                input int row, input int col, input int cha, input int dout);
        vec_t v;
        v.start = st;  v.abort = ab;  v.ack = ak;  v.cont = 1'b0;
        v.vld   = vl;  v.din   = WIDTH'(din);
        v.rdy   = rdy; v.tv    = tv;  v.bsy = bsy;
        v.row   = 3'(row); v.col = 3'(col); v.cha = 2'(cha);
        v.dout  = WIDTH'(dout);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic rdy, input logic tv, input logic bsy,
                              input int row, input int col, input int cha, input int dout);
        check({tag, ".s_ready"},      32'(s_ready),      32'(rdy));
        check({tag, ".tensor_valid"}, 32'(tensor_valid), 32'(tv));
        check({tag, ".busy"},         32'(busy),         32'(bsy));
        check({tag, ".row_addr"},     32'(row_addr),     32'(row));
        check({tag, ".col_addr"},     32'(col_addr),     32'(col));
        check({tag, ".cha_addr"},     32'(cha_addr),     32'(cha));
        check({tag, ".data_out"},     32'(data_out),     32'(dout));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start      = 1'b0;
        abort      = 1'b0;
        tensor_ack = 1'b0;
        s_valid    = 1'b0;
    endtask

    task automatic check_tensor(input string name, input int offset);
        int errs;
        errs = 0;
        for (int i = 0; i < 192; i++) begin
            if (tens[i] !== WIDTH'(i + offset)) begin
                if (errs == 0) $display("  cell %0d holds %0d, wanted %0d", i, tens[i], i + offset);
                errs++;
            end
        end
        check(name, errs, 0);
    endtask

    // Streams one frame (value = index + offset); the state must already be LOAD
    task automatic load_frame(input string name, input int offset, input bit gaps);
        int idx;
        int cyc;
        int addr_err;
        int rdy_err;
        idx = 0; cyc = 0; addr_err = 0; rdy_err = 0;
        while (idx < 192 && cyc < 4000) begin
            if (s_ready !== 1'b1) rdy_err++;
            s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = WIDTH'(idx + offset);
            step();
            cyc++;
            if (s_valid) idx++;
            if (idx > 0) begin
                if (int'(row_addr) != (idx - 1) / 24 ||
                    int'(col_addr) != ((idx - 1) % 24) / 3 ||
                    int'(cha_addr) != (idx - 1) % 3 ||
                    data_out !== WIDTH'(idx - 1 + offset)) addr_err++;
            end
        end
        s_valid = 1'b0;
        check({name, ".accepts"},    idx, 192);
        check({name, ".addr_track"}, addr_err, 0);
        check({name, ".ready_load"}, rdy_err, 0);
        // Edge E of the last accept: DRAIN, not yet valid
        check({name, ".drain_tv"},    32'(tensor_valid), 0);
        check({name, ".drain_ready"}, 32'(s_ready), 0);
        check({name, ".drain_busy"},  32'(busy), 1);
        step();
        // Edge E+1: FULL, builder has captured element 191
        check({name, ".full_tv"}, 32'(tensor_valid), 1);
        check_tensor({name, ".tensor"}, offset);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int errs;
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        cont  = 1'b0;
        s_data = '0;
        idle_inputs();

        vt[0]  = mk(1, 0, 0, 0,  0,   1, 0, 1,  0, 0, 0,  0);
        vt[1]  = mk(0, 0, 0, 1,  5,   1, 0, 1,  0, 0, 0,  5);
        vt[2]  = mk(1, 0, 0, 0,  6,   1, 0, 1,  0, 0, 0,  5);
        vt[3]  = mk(0, 0, 1, 1,  7,   1, 0, 1,  0, 0, 1,  7);
        vt[4]  = mk(0, 0, 0, 1,  9,   1, 0, 1,  0, 0, 2,  9);
        vt[5]  = mk(0, 0, 0, 1, 11,   1, 0, 1,  0, 1, 0, 11);
        vt[6]  = mk(0, 1, 0, 0,  0,   0, 0, 0,  0, 1, 0, 11);
        vt[7]  = mk(0, 0, 0, 1, 13,   0, 0, 0,  0, 1, 0, 11);
        vt[8]  = mk(1, 1, 0, 0,  0,   0, 0, 0,  0, 1, 0, 11);
        vt[9]  = mk(1, 0, 0, 0,  0,   1, 0, 1,  0, 1, 0, 11);
        vt[10] = mk(0, 0, 0, 1, 20,   1, 0, 1,  0, 0, 0, 20);
        vt[11] = mk(0, 1, 0, 0,  0,   0, 0, 0,  0, 0, 0, 20);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_outs("reset", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step();

        // Table-driven single-cycle behaviour
        for (int i = 0; i < 12; i++) begin
            start      = vt[i].start;
            abort      = vt[i].abort;
            tensor_ack = vt[i].ack;
            cont       = vt[i].cont;
            s_valid    = vt[i].vld;
            s_data     = vt[i].din;
            step();
            check_outs($sformatf("vec%0d", i), vt[i].rdy, vt[i].tv, vt[i].bsy,
                       int'(vt[i].row), int'(vt[i].col), int'(vt[i].cha), int'(vt[i].dout));
        end
        idle_inputs();

        // Asynchronous reset in the middle of a load
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            s_valid = 1'b1;
            s_data  = WIDTH'(i + 300);
            step();
        end
        s_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_outs("midreset", 0, 0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b1;
        step();
        start = 1'b1;
        step();
        start   = 1'b0;
        s_valid = 1'b1;
        s_data  = WIDTH'(77);
        step();
        s_valid = 1'b0;
        check_outs("after_reset", 1, 0, 1, 0, 0, 0, 77);
        abort = 1'b1;
        step();
        abort = 1'b0;

        // Frame 1: gap-free, value = index
        start = 1'b1;
        step();
        start = 1'b0;
        load_frame("frame1", 0, 1'b0);
`ifdef TENSOR_LOAD_CTRL_CNT_EN
        check("frame1.frame_cnt", 32'(frame_cnt), 1);
`endif

        // Hold FULL for 20 cycles
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tensor_valid !== 1'b1 || s_ready !== 1'b0 || data_out !== WIDTH'(191)) errs++;
        end
        check("hold_full", errs, 0);
        check_tensor("hold_tensor", 0);

        // Continuous-mode ack: straight back into LOAD
        tensor_ack = 1'b1;
        cont       = 1'b1;
        step();
        tensor_ack = 1'b0;
        cont       = 1'b0;
        check("cont_ack.tensor_valid", 32'(tensor_valid), 0);
        check("cont_ack.s_ready",      32'(s_ready), 1);

        // Frame 2: random gaps, value = index + 1000
        load_frame("frame2", 1000, 1'b1);
`ifdef TENSOR_LOAD_CTRL_CNT_EN
        check("frame2.frame_cnt", 32'(frame_cnt), 2);
`endif
        tensor_ack = 1'b1;
        step();
        tensor_ack = 1'b0;
        check("ack_stop.busy",    32'(busy), 0);
        check("ack_stop.s_ready", 32'(s_ready), 0);

        // Frame 3: random gaps, value = index, must match the gap-free tensor
        start = 1'b1;
        step();
        start = 1'b0;
        load_frame("frame3", 0, 1'b1);
        // Abort beats a continuous-mode ack in FULL
        abort      = 1'b1;
        tensor_ack = 1'b1;
        cont       = 1'b1;
        step();
        idle_inputs();
        cont = 1'b0;
        check("full_abort.s_ready",      32'(s_ready), 0);
        check("full_abort.tensor_valid", 32'(tensor_valid), 0);
        check("full_abort.busy",         32'(busy), 0);

        // Abort together with ack after 100 accepts
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            s_valid = 1'b1;
            s_data  = WIDTH'(i + 2000);
            step();
        end
        s_valid    = 1'b0;
        check_outs("load100", 1, 0, 1, 4, 1, 0, 2099);
        abort      = 1'b1;
        tensor_ack = 1'b1;
        step();
        idle_inputs();
        check_outs("abort_ack", 0, 0, 0, 4, 1, 0, 2099);
        start = 1'b1;
        step();
        start   = 1'b0;
        s_valid = 1'b1;
        s_data  = WIDTH'(555);
        step();
        s_valid = 1'b0;
        check_outs("restart", 1, 0, 1, 0, 0, 0, 555);
        step();
        check("restart.tensor0", 32'(tens[0]), 555);
`ifdef TENSOR_LOAD_CTRL_CNT_EN
        check("abort.frame_cnt", 32'(frame_cnt), 3);
`endif
        abort = 1'b1;
        step();
        abort = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
